// File: rtl/counter_pkg.sv
// Shared constants and helpers for the free-running binary counter.
// Gray-code output is enabled with COUNTER_4BIT_GRAY_EN.
package counter_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int MAX_WIDTH     = 16;

    function automatic logic [MAX_WIDTH-1:0] bin2gray(
        input logic [MAX_WIDTH-1:0] value
    );
        return value ^ (value >> 1);
    endfunction

    // All-ones value for a counter of width w.
    function automatic logic [MAX_WIDTH-1:0] max_value(input int w);
        return MAX_WIDTH'((1 << w) - 1);
    endfunction

endpackage

// File: rtl/counter_4bit_incr.sv
// Combinational next-state unit: increment modulo 2^WIDTH and flag the wrap.
// The Gray path it feeds is present only with COUNTER_4BIT_GRAY_EN.
module counter_4bit_incr
    import counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] next_count,
    output logic             wrap
);

    assign wrap       = (count == WIDTH'(max_value(WIDTH)));
    assign next_count = count + WIDTH'(1);

endmodule

// File: rtl/counter_4bit.sv
// Free-running up-counter with terminal-count and overflow flags.
// COUNTER_4BIT_GRAY_EN adds a registered Gray-coded copy of count.
module counter_4bit
    import counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
`ifdef COUNTER_4BIT_GRAY_EN
   ,output logic [WIDTH-1:0] count_gray
`endif
);

    logic [WIDTH-1:0] next_count;
    logic             wrap;

    counter_4bit_incr #(
        .WIDTH (WIDTH)
    ) u_incr (
        .count      (count),
        .next_count (next_count),
        .wrap       (wrap)
    );

    // rst is active-low and asynchronous; ovf lands with count == 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            count <= next_count;
            ovf   <= wrap;
        end
    end

    assign tc = (count == WIDTH'(max_value(WIDTH)));

`ifdef COUNTER_4BIT_GRAY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_gray <= '0;
        end else begin
            count_gray <= WIDTH'(bin2gray(MAX_WIDTH'(next_count)));
        end
    end
`endif

endmodule

// File: tb/tb_counter_4bit.sv
// Directed bench for counter_4bit at WIDTH 4 and WIDTH 3.
// Gray checks run when COUNTER_4BIT_GRAY_EN is defined.
module tb_counter_4bit;
    import counter_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] count;
    logic       tc;
    logic       ovf;
    logic [2:0] c3;
    logic       tc3;
    logic       ovf3;
`ifdef COUNTER_4BIT_GRAY_EN
    logic [3:0] cg;
    logic [3:0] pg;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    counter_4bit dut4 (
        .clk   (clk),
        .rst   (rst),
        .count (count),
        .tc    (tc),
        .ovf   (ovf)
`ifdef COUNTER_4BIT_GRAY_EN
       ,.count_gray (cg)
`endif
    );

    counter_4bit #(
        .WIDTH (3)
    ) dut3 (
        .clk   (clk),
        .rst   (rst),
        .count (c3),
        .tc    (tc3),
        .ovf   (ovf3)
`ifdef COUNTER_4BIT_GRAY_EN
       ,.count_gray ()
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int e4, input int e3,
                             input bit eo4, input bit eo3);
        chk({tag, "_count"}, 32'(count), 32'(e4));
        chk({tag, "_tc"}, 32'(tc), 32'(e4 == 15 && !eo4 ? 1 : (e4 == 15)));
        chk({tag, "_ovf"}, 32'(ovf), 32'(eo4));
        chk({tag, "_c3"}, 32'(c3), 32'(e3));
        chk({tag, "_tc3"}, 32'(tc3), 32'(e3 == 7));
        chk({tag, "_ovf3"}, 32'(ovf3), 32'(eo3));
`ifdef COUNTER_4BIT_GRAY_EN
        chk({tag, "_gray"}, 32'(cg), 32'(bin2gray(16'(e4))));
`endif
    endtask

    task automatic at(input int t);
        #(t - int'($time));
    endtask

    initial begin
        at(2);
        check_all("reset", 0, 0, 1'b0, 1'b0);
        at(10);
        rst = 1'b1;

        at(16);
        for (int i = 1; i <= 5; i++) begin
            check_all("pwrup", i, i, 1'b0, 1'b0);
            if (i < 5) #10;
        end

        // Reset lands between edges and must act before the 65 ns edge.
        at(60);
        rst = 1'b0;
        at(61);
        check_all("async_mid", 0, 0, 1'b0, 1'b0);
        at(66);
        check_all("held_mid", 0, 0, 1'b0, 1'b0);
        at(70);
        rst = 1'b1;

`ifdef COUNTER_4BIT_GRAY_EN
        pg = 4'd0;
`endif
        for (int k = 1; k <= 25; k++) begin
            at(66 + 10 * k);
            check_all("run", k % 16, k % 8, (k % 16) == 0, (k % 8) == 0);
`ifdef COUNTER_4BIT_GRAY_EN
            chk("gray_step", 32'($countones(cg ^ pg)), 32'd1);
            pg = cg;
`endif
        end

        // count is 9 here; drop reset between edges.
        at(320);
        rst = 1'b0;
        at(321);
        check_all("async9", 0, 0, 1'b0, 1'b0);
        at(324);
        check_all("async9_hold", 0, 0, 1'b0, 1'b0);
        at(330);
        rst = 1'b1;
        at(336);
        check_all("restart", 1, 1, 1'b0, 1'b0);
        at(346);
        check_all("restart2", 2, 2, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
